// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   XLEN_DEFAULT : default datapath / address width
//   REG_W        : register-index width
//   state_t      : stage controller states
package mem_access_stage_pkg;

   localparam int XLEN_DEFAULT = 64;
   localparam int REG_W        = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus.
//   master : the memory-access stage (drives req/we/addr/wdata, receives ack/rdata)
//   slave  : the data memory
// dmem_ack is a one-cycle completion pulse; dmem_rdata is valid with it.
interface mem_access_stage_if
   import mem_access_stage_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
);
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_access_stage_access_timeout_counter.sv
// Cycle counter bounding how long an access waits for the memory ack.
//   clk, rst : clock, synchronous active-high reset
//   clear    : force count to zero (takes priority over enable)
//   enable   : advance count by one
//   terminal : count has reached TIMEOUT-1
module access_timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);
   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign terminal = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: consumer end of the EX/MEM register.
// Issues 64-bit data-memory loads/stores over a req/ack handshake, stalls the
// front of the pipeline while an access is in flight, resolves branches and
// produces the MEM/WB fields.
//   clk, rst                         : clock, synchronous active-high reset
//   pc_plus_imm, alu_result, rd2, rd : EX/MEM datapath fields
//   mem_read .. zero                 : EX/MEM control bits
//   dmem                             : data-memory bus (master side)
//   stall                            : freeze PC, IF/ID, ID/EX, EX/MEM
//   pc_src, branch_target            : taken-branch redirect
//   wb_data, wb_rd, wb_reg_write     : MEM/WB fields
//   mem_error                        : one-cycle pulse on misalignment or timeout
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int XLEN    = XLEN_DEFAULT,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  pc_plus_imm,
   input  logic [XLEN-1:0]  alu_result,
   input  logic [XLEN-1:0]  rd2,
   input  logic [REG_W-1:0] rd,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic             memToReg,
   input  logic             branch,
   input  logic             reg_write,
   input  logic             zero,
   mem_access_stage_if.master dmem,
   output logic             stall,
   output logic             pc_src,
   output logic [XLEN-1:0]  branch_target,
   output logic [XLEN-1:0]  wb_data,
   output logic [REG_W-1:0] wb_rd,
   output logic             wb_reg_write,
   output logic             mem_error
);
   state_t state, state_nxt;

   logic access, misaligned, start, terminal;

   // Captured copy of the instruction being served; EX/MEM is frozen by stall
   // but is deliberately not trusted once the access has started.
   logic             we_q;
   logic             mem_to_reg_q;
   logic             reg_write_q;
   logic [REG_W-1:0] rd_q;
   logic [XLEN-1:0]  addr_q;
   logic [XLEN-1:0]  wdata_q;

   assign access     = mem_read | mem_write;
   assign misaligned = access & (alu_result[2:0] != 3'b000);
   assign start      = access & ~misaligned;

   assign dmem.dmem_req   = (state == ACCESS);
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;

   assign branch_target = pc_plus_imm;

   access_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear    (state != ACCESS),
      .enable   (state == ACCESS),
      .terminal (terminal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // An access (even alongside a branch) blocks the redirect; misaligned
   // accesses never stall because no request is issued.
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      pc_src    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stall     = 1'b1;
               state_nxt = ACCESS;
            end else if (!access) begin
               pc_src = branch & zero;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (dmem.dmem_ack || terminal) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q         <= 1'b0;
         mem_to_reg_q <= 1'b0;
         reg_write_q  <= 1'b0;
         rd_q         <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wb_data      <= '0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         mem_error    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mem_error <= 1'b0;
               if (!access) begin
                  wb_data      <= alu_result;
                  wb_rd        <= rd;
                  wb_reg_write <= reg_write;
               end else if (misaligned) begin
                  wb_reg_write <= 1'b0;
                  mem_error    <= 1'b1;
               end else begin
                  addr_q       <= alu_result;
                  wdata_q      <= rd2;
                  we_q         <= mem_write;
                  mem_to_reg_q <= memToReg;
                  reg_write_q  <= reg_write;
                  rd_q         <= rd;
                  wb_reg_write <= 1'b0;
               end
            end
            ACCESS: begin
               if (dmem.dmem_ack) begin
                  // A load not routed to the register file writes back the address.
                  wb_data      <= (!we_q && mem_to_reg_q) ? dmem.dmem_rdata : addr_q;
                  wb_rd        <= rd_q;
                  wb_reg_write <= reg_write_q & ~we_q;
               end else if (terminal) begin
                  wb_reg_write <= 1'b0;
                  mem_error    <= 1'b1;
               end
            end
            default: begin
               // DONE: result was visible for exactly one cycle.
               wb_reg_write <= 1'b0;
               mem_error    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writeback
// events and memory requests; a monitor pops and compares them when the DUT
// presents wb_reg_write/mem_error or raises dmem_req.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   typedef struct {
      logic        err;
      logic [63:0] data;
      logic [4:0]  rd;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
   } req_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc_plus_imm, alu_result, rd2;
   logic [4:0]  rd;
   logic        mem_read, mem_write, memToReg, branch, reg_write, zero;
   logic        stall, pc_src, wb_reg_write, mem_error;
   logic [63:0] branch_target, wb_data;
   logic [4:0]  wb_rd;

   int checks = 0;
   int errors = 0;
   wb_exp_t  wbq[$];
   req_exp_t reqq[$];

   mem_access_stage_if #(.XLEN(64)) dmem_bus ();

   mem_access_stage #(.XLEN(64), .TIMEOUT(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_plus_imm   (pc_plus_imm),
      .alu_result    (alu_result),
      .rd2           (rd2),
      .rd            (rd),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .memToReg      (memToReg),
      .branch        (branch),
      .reg_write     (reg_write),
      .zero          (zero),
      .dmem          (dmem_bus),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .wb_data       (wb_data),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .mem_error     (mem_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_nop();
      mem_read = 0; mem_write = 0; memToReg = 0; branch = 0; reg_write = 0; zero = 0;
      rd = 0; alu_result = 0; rd2 = 0; pc_plus_imm = 0;
   endtask

   task automatic drive(input logic mr, input logic mw, input logic m2r, input logic br,
                        input logic rw, input logic z, input logic [4:0] r,
                        input logic [63:0] alu, input logic [63:0] d2, input logic [63:0] pc);
      mem_read = mr; mem_write = mw; memToReg = m2r; branch = br;
      reg_write = rw; zero = z; rd = r; alu_result = alu; rd2 = d2; pc_plus_imm = pc;
   endtask

   task automatic push_wb(input logic err, input logic [63:0] data, input logic [4:0] r);
      wb_exp_t e;
      e.err = err; e.data = data; e.rd = r;
      wbq.push_back(e);
   endtask

   task automatic push_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
      req_exp_t q;
      q.we = we; q.addr = addr; q.wdata = wdata;
      reqq.push_back(q);
   endtask

   task automatic monitor();
      logic     req_prev;
      wb_exp_t  e;
      req_exp_t q;
      req_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (wb_reg_write || mem_error) begin
            if (wbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL wb_unexpected: wb_reg_write=%0b mem_error=%0b, none expected",
                        wb_reg_write, mem_error);
            end else begin
               e = wbq.pop_front();
               if (e.err) begin
                  check("err_mem_error", mem_error, 1);
                  check("err_wb_reg_write", wb_reg_write, 0);
               end else begin
                  check("wb_reg_write", wb_reg_write, 1);
                  check("wb_mem_error", mem_error, 0);
                  check("wb_data", wb_data, e.data);
                  check("wb_rd", wb_rd, e.rd);
               end
            end
         end
         if (dmem_bus.dmem_req && !req_prev) begin
            if (reqq.size() == 0) begin
               checks++; errors++;
               $display("FAIL req_unexpected: dmem_req=1 addr=0x%0h, none expected", dmem_bus.dmem_addr);
            end else begin
               q = reqq.pop_front();
               check("req_we", dmem_bus.dmem_we, q.we);
               check("req_addr", dmem_bus.dmem_addr, q.addr);
               check("req_wdata", dmem_bus.dmem_wdata, q.wdata);
            end
         end
         req_prev = dmem_bus.dmem_req;
      end
   endtask

   // Runs one aligned access from its IDLE cycle through DONE; memory acks in
   // the ack_at-th request cycle (0 = never).
   task automatic run_op(input int ack_at, input logic [63:0] rdata,
                         output int stall_cyc, output int req_cyc);
      int c;
      bit done;
      stall_cyc = 0; req_cyc = 0; done = 0; c = 0;
      while (!done && c < 40) begin
         @(negedge clk);
         check("pc_src_busy", pc_src, 0);
         if (stall) stall_cyc++;
         if (dmem_bus.dmem_req) req_cyc++;
         if (c > 0 && !stall) done = 1;
         dmem_bus.dmem_ack   = dmem_bus.dmem_req && (req_cyc == ack_at);
         dmem_bus.dmem_rdata = dmem_bus.dmem_ack ? rdata : 64'hBAD0_BAD0_BAD0_BAD0;
         @(posedge clk);
         #1;
         dmem_bus.dmem_ack = 1'b0;
         c++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL op_bound: access still stalling after %0d cycles, required completion", c);
      end
      set_nop();
   endtask

   initial begin
      int sc, rc;
      rst = 1'b1;
      set_nop();
      dmem_bus.dmem_ack   = 1'b0;
      dmem_bus.dmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wb_reg_write", wb_reg_write, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_rd", wb_rd, 0);
      check("rst_mem_error", mem_error, 0);
      check("rst_dmem_req", dmem_bus.dmem_req, 0);
      check("rst_dmem_we", dmem_bus.dmem_we, 0);
      check("rst_dmem_addr", dmem_bus.dmem_addr, 0);
      check("rst_dmem_wdata", dmem_bus.dmem_wdata, 0);
      check("rst_stall", stall, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      fork
         monitor();
      join_none

      // ALU ops, back to back
      drive(0, 0, 0, 0, 1, 0, 5'd5, 64'h2A, 64'h0, 64'h0);
      push_wb(0, 64'h2A, 5'd5);
      @(negedge clk); check("alu1_stall", stall, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1, 0, 5'd31, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'h0);
      push_wb(0, 64'hFFFF_FFFF_FFFF_FFF0, 5'd31);
      @(negedge clk); check("alu2_stall", stall, 0);
      @(posedge clk); #1;
      set_nop();

      // Branch resolution in IDLE
      @(posedge clk); #1;
      drive(0, 0, 0, 1, 0, 1, 5'd0, 64'h0, 64'h0, 64'h400);
      #1;
      check("br_taken_pc_src", pc_src, 1);
      check("br_target", branch_target, 64'h400);
      zero = 1'b0;
      #1;
      check("br_not_taken_pc_src", pc_src, 0);
      set_nop();
      @(posedge clk); #1;

      // Load, ack in 3rd ACCESS cycle; branch bits set to confirm access priority
      drive(1, 0, 1, 1, 1, 1, 5'd7, 64'h100, 64'h0, 64'h880);
      #1;
      check("load_branch_pc_src", pc_src, 0);
      push_req(0, 64'h100, 64'h0);
      push_wb(0, 64'hDEAD_BEEF, 5'd7);
      run_op(3, 64'hDEAD_BEEF, sc, rc);
      check("load_stall_cycles", sc, 4);
      check("load_req_cycles", rc, 3);

      // Store, ack in 1st ACCESS cycle: no writeback even with reg_write set
      drive(0, 1, 0, 0, 1, 0, 5'd9, 64'h208, 64'h55, 64'h0);
      push_req(1, 64'h208, 64'h55);
      run_op(1, 64'h0, sc, rc);
      check("store_stall_cycles", sc, 2);
      check("store_req_cycles", rc, 1);

      // Load without memToReg writes back the address
      drive(1, 0, 0, 0, 1, 0, 5'd11, 64'h48, 64'h0, 64'h0);
      push_req(0, 64'h48, 64'h0);
      push_wb(0, 64'h48, 5'd11);
      run_op(2, 64'h1234, sc, rc);
      check("ld_addr_stall_cycles", sc, 3);

      // Misaligned load
      drive(1, 0, 1, 0, 1, 0, 5'd3, 64'h103, 64'h0, 64'h0);
      push_wb(1, 64'h0, 5'd0);
      @(negedge clk);
      check("mis_stall", stall, 0);
      check("mis_dmem_req", dmem_bus.dmem_req, 0);
      @(posedge clk); #1;
      set_nop();
      @(negedge clk); check("mis_stall_after", stall, 0);
      @(posedge clk); #1;

      // Load with no ack: timeout after 16 request cycles
      drive(1, 0, 1, 0, 1, 0, 5'd4, 64'h300, 64'h0, 64'h0);
      push_req(0, 64'h300, 64'h0);
      push_wb(1, 64'h0, 5'd0);
      run_op(0, 64'h0, sc, rc);
      check("to_req_cycles", rc, 16);
      check("to_stall_cycles", sc, 17);
      dmem_bus.dmem_ack   = 1'b1;
      dmem_bus.dmem_rdata = 64'h5555_AAAA;
      @(negedge clk);
      check("late_ack_stall", stall, 0);
      check("late_ack_req", dmem_bus.dmem_req, 0);
      @(posedge clk); #1;
      dmem_bus.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset during the 2nd ACCESS cycle, with an ack arriving at the same edge
      drive(1, 0, 1, 0, 1, 0, 5'd6, 64'h500, 64'h77, 64'h0);
      push_req(0, 64'h500, 64'h77);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      set_nop();
      dmem_bus.dmem_ack   = 1'b1;
      dmem_bus.dmem_rdata = 64'hCAFE;
      @(posedge clk); #1;
      dmem_bus.dmem_ack = 1'b0;
      @(negedge clk);
      check("mid_rst_dmem_req", dmem_bus.dmem_req, 0);
      check("mid_rst_dmem_we", dmem_bus.dmem_we, 0);
      check("mid_rst_dmem_addr", dmem_bus.dmem_addr, 0);
      check("mid_rst_dmem_wdata", dmem_bus.dmem_wdata, 0);
      check("mid_rst_wb_data", wb_data, 0);
      check("mid_rst_wb_rd", wb_rd, 0);
      check("mid_rst_wb_reg_write", wb_reg_write, 0);
      check("mid_rst_mem_error", mem_error, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_pc_src", pc_src, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("end_wb_queue_empty", wbq.size(), 0);
      check("end_req_queue_empty", reqq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM interface.
- Takes the EX/MEM register outputs and performs data-memory loads and stores over a req/ack handshake, stalling the front of the pipeline while an access is in flight.
- Resolves branches and produces the fields written into MEM/WB.
- Sits between the EX/MEM register, data memory, the hazard/stall logic and the MEM/WB register.

Parameters:
- XLEN, 64, datapath and address width.
- TIMEOUT, 16, maximum cycles in ACCESS waiting for dmem_ack before abort; legal range is 2 or more.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pc_plus_imm  in  XLEN  branch target from EX/MEM
- alu_result  in  XLEN  memory address, or ALU value for writeback
- rd2  in  XLEN  store data
- rd  in  5  destination register
- mem_read, mem_write, memToReg, branch, reg_write, zero  in  1 each  EX/MEM control
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  captured address
- dmem_wdata  out  XLEN  captured store data
- dmem_ack  in  1  memory completion; one-cycle pulse
- dmem_rdata  in  XLEN  load data, valid with dmem_ack
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- pc_src  out  1  branch taken; flush younger stages
- branch_target  out  XLEN  pc_plus_imm passthrough
- wb_data  out  XLEN  value for MEM/WB
- wb_rd  out  5  destination for MEM/WB
- wb_reg_write  out  1  MEM/WB write enable
- mem_error  out  1  one-cycle pulse on misaligned access or timeout

Behaviour:
- Reset:
  - state=IDLE, counter=0.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_data, wb_rd, wb_reg_write, mem_error all 0.
  - Reset mid-access aborts the access: no ack is honoured and no writeback occurs.
- access = mem_read | mem_write. misaligned = access & (alu_result[2:0] != 0). All accesses are 64-bit only.
- States are IDLE, ACCESS, DONE.
- IDLE, no access:
  - stall=0.
  - Next edge: wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write (latency 1).
  - pc_src = branch & zero, combinational; branch_target = pc_plus_imm.
- IDLE, misaligned:
  - stall=0; no request issued.
  - Next edge: wb_reg_write=0 and mem_error=1 for one cycle.
- IDLE, aligned access:
  - stall=1 combinationally.
  - Next edge: capture dmem_addr=alu_result, dmem_wdata=rd2, dmem_we=mem_write, plus memToReg, rd, reg_write; counter=0; wb_reg_write=0; go to ACCESS.
- ACCESS:
  - dmem_req=1, stall=1, counter increments each cycle.
  - dmem_ack=1: wb_data = (load & memToReg) ? dmem_rdata : captured address; wb_rd and wb_reg_write from captured fields (a store gives wb_reg_write=0); go to DONE.
  - No ack with counter==TIMEOUT-1: wb_reg_write=0, mem_error=1 next cycle, go to DONE.
  - In both cases dmem_req drops on that edge.
- DONE:
  - stall=0, dmem_req=0; the pipeline advances at the end of this cycle.
  - EX/MEM contents are ignored, because they are the instruction just served.
  - wb outputs hold the result for exactly this cycle.
  - Next edge: wb_reg_write=0, mem_error=0, go to IDLE.
- pc_src is forced 0 whenever stall=1 or state != IDLE.
- Each instruction presents wb_reg_write=1 for at most one cycle.
- dmem_ack outside ACCESS is ignored.
- mem_error is always a single-cycle pulse and is never sticky.
- Counter width is clog2(TIMEOUT).
- A branch with access set (illegal encoding): the access takes priority and pc_src=0.

Decomposition:
- Shared pipeline package holds:
  - state encoding enum (IDLE, ACCESS, DONE);
  - XLEN default;
  - register-index width 5.
- One natural sub-module, access_timeout_counter: clear, enable, and a terminal flag at TIMEOUT-1.

Test Plan:
- ALU op (reg_write=1, rd=5, alu_result=0x2A, no access) -> next cycle wb_rd=5, wb_data=0x2A, wb_reg_write=1; stall never asserted.
- Load (mem_read=1, memToReg=1, addr=0x100, rd=7), memory acks after 3 cycles with rdata=0xDEADBEEF:
  - stall high 4 cycles;
  - dmem_addr=0x100, dmem_we=0;
  - DONE cycle shows wb_data=0xDEADBEEF, wb_rd=7, wb_reg_write=1 for exactly 1 cycle.
- Store (mem_write=1, addr=0x208, rd2=0x55) with ack in 1st ACCESS cycle -> dmem_we=1, dmem_wdata=0x55, wb_reg_write=0, mem_error=0.
- Load to addr=0x103 -> dmem_req never asserted, stall stays 0, mem_error=1 for one cycle, wb_reg_write=0.
- Load with no ack, TIMEOUT=16 -> dmem_req high exactly 16 cycles, then mem_error pulse, return to IDLE; an ack arriving afterwards is ignored.
- Branch=1, zero=1, pc_plus_imm=0x400 in IDLE -> pc_src=1 and branch_target=0x400 same cycle; the same branch with zero=0 gives pc_src=0.
- rst asserted in the 2nd ACCESS cycle -> next cycle all outputs 0, state IDLE, no writeback.
